// File: rtl/ov5640_sccb_cfg_seq.sv
// ov5640_sccb_cfg_seq: walks the OV5640 register LUT once after reset and
// programs every entry into the sensor through the Gowin I2C master
// register interface (I_clk domain, 27 MHz).
//
// Ports:
//   I_clk, I_rst_n          clock, asynchronous active-low reset
//   O_lut_index, I_lut_data LUT address / combinational LUT entry
//                           {dev addr[31:24], reg addr[23:8], value[7:0]}
//   O_tx_en, O_waddr,       one-cycle register write strobe to the master
//   O_wdata
//   O_rx_en, O_raddr,       one-cycle register read strobe; I_rdata is valid
//   I_rdata                 on the cycle after O_rx_en
//   I_iic_int               master interrupt, level, cleared by IACK
//   O_busy, O_done, O_error sequence status; done and error are sticky
//
// Optional feature: define OV5640_CFG_ACK_CHECK_EN to read SR after every
// byte and retry an entry (STOP, then restart from byte 0) on NACK, giving
// up with O_error after MAX_RETRY retries. Undefined: O_rx_en/O_raddr stay 0
// and I_rdata is ignored.
module ov5640_sccb_cfg_seq #(
   parameter int unsigned LUT_SIZE    = 252,
   parameter logic [15:0] PRESCALE    = 16'd53,
   parameter int unsigned INIT_DELAY  = 540_000,
   parameter int unsigned RESET_DELAY = 135_000,
   parameter int unsigned INT_TIMEOUT = 27_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   output logic [9:0]  O_lut_index,
   input  logic [31:0] I_lut_data,
   output logic        O_tx_en,
   output logic [2:0]  O_waddr,
   output logic [7:0]  O_wdata,
   output logic        O_rx_en,
   output logic [2:0]  O_raddr,
   input  logic [7:0]  I_rdata,
   input  logic        I_iic_int,
   output logic        O_busy,
   output logic        O_done,
   output logic        O_error
);

   localparam int unsigned DLY_A   = (INIT_DELAY > RESET_DELAY) ? INIT_DELAY : RESET_DELAY;
   localparam int unsigned DLY_MAX = (DLY_A > INT_TIMEOUT) ? DLY_A : INT_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(DLY_MAX + 1);
   localparam int unsigned IDX_W   = 10;

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY - 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_DELAY - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(INT_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);

   localparam logic [2:0] A_PRER_LO = 3'd0;
   localparam logic [2:0] A_PRER_HI = 3'd1;
   localparam logic [2:0] A_CTR     = 3'd2;
   localparam logic [2:0] A_TXR     = 3'd3;
   localparam logic [2:0] A_CR      = 3'd4;

   localparam logic [7:0] CR_STA_WR = 8'h90;
   localparam logic [7:0] CR_WR     = 8'h10;
   localparam logic [7:0] CR_WR_STO = 8'h50;
   localparam logic [7:0] CR_IACK   = 8'h01;
   localparam logic [7:0] CTR_EN    = 8'h80;

`ifdef OV5640_CFG_ACK_CHECK_EN
   localparam logic [7:0]  CR_STO = 8'h40;
   localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);
`endif

   typedef enum logic [4:0] {
      S_PWR_WAIT, S_INIT, S_LOAD, S_TX, S_CMD, S_WAIT_INT, S_IACK,
      S_NEXT, S_RST_WAIT, S_DONE, S_ERROR
`ifdef OV5640_CFG_ACK_CHECK_EN
      , S_RD_REQ, S_RD_WAIT, S_RD_CHK, S_STOP_CMD, S_STOP_WAIT, S_STOP_IACK
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      entry_q, entry_d;
   logic [1:0]       byte_q, byte_d;
   logic [IDX_W-1:0] idx_d;
   logic             tx_en_d, rx_en_d, busy_d, done_d, error_d;
   logic [2:0]       waddr_d, raddr_d;
   logic [7:0]       wdata_d;
   logic             soft_rst_c;
   logic             unused_c;
`ifdef OV5640_CFG_ACK_CHECK_EN
   logic [RTY_W-1:0] retry_q, retry_d;
   assign unused_c = ^I_rdata[6:0];
`else
   assign unused_c = ^{I_rdata, 32'(MAX_RETRY)};
`endif

   // A write of 0x3008 with bit7 set soft-resets the sensor; it needs settle time.
   assign soft_rst_c = (entry_q[23:8] == 16'h3008) && entry_q[7];

   // State and output registers
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q     <= S_PWR_WAIT;
         cnt_q       <= '0;
         entry_q     <= '0;
         byte_q      <= '0;
         O_lut_index <= '0;
         O_tx_en     <= 1'b0;
         O_waddr     <= '0;
         O_wdata     <= '0;
         O_rx_en     <= 1'b0;
         O_raddr     <= '0;
         O_busy      <= 1'b0;
         O_done      <= 1'b0;
         O_error     <= 1'b0;
`ifdef OV5640_CFG_ACK_CHECK_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         entry_q     <= entry_d;
         byte_q      <= byte_d;
         O_lut_index <= idx_d;
         O_tx_en     <= tx_en_d;
         O_waddr     <= waddr_d;
         O_wdata     <= wdata_d;
         O_rx_en     <= rx_en_d;
         O_raddr     <= raddr_d;
         O_busy      <= busy_d;
         O_done      <= done_d;
         O_error     <= error_d;
`ifdef OV5640_CFG_ACK_CHECK_EN
         retry_q     <= retry_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      entry_d = entry_q;
      byte_d  = byte_q;
      idx_d   = O_lut_index;
      tx_en_d = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      rx_en_d = 1'b0;
      raddr_d = '0;
      busy_d  = O_busy;
      done_d  = O_done;
      error_d = O_error;
`ifdef OV5640_CFG_ACK_CHECK_EN
      retry_d = retry_q;
`endif
      unique case (state_q)
         S_PWR_WAIT: begin
            busy_d = 1'b1;
            if (cnt_q == INIT_LAST) begin
               cnt_d   = '0;
               state_d = S_INIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // Prescaler low, prescaler high, core enable on consecutive cycles
         S_INIT: begin
            tx_en_d = 1'b1;
            case (cnt_q[1:0])
               2'd0:    begin waddr_d = A_PRER_LO; wdata_d = PRESCALE[7:0];  end
               2'd1:    begin waddr_d = A_PRER_HI; wdata_d = PRESCALE[15:8]; end
               default: begin waddr_d = A_CTR;     wdata_d = CTR_EN;         end
            endcase
            if (cnt_q[1:0] == 2'd2) begin
               cnt_d   = '0;
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_LOAD: begin
            entry_d = I_lut_data;
            byte_d  = '0;
`ifdef OV5640_CFG_ACK_CHECK_EN
            retry_d = '0;
`endif
            state_d = S_TX;
         end
         S_TX: begin
            tx_en_d = 1'b1;
            waddr_d = A_TXR;
            case (byte_q)
               2'd0:    wdata_d = entry_q[31:24];
               2'd1:    wdata_d = entry_q[23:16];
               2'd2:    wdata_d = entry_q[15:8];
               default: wdata_d = entry_q[7:0];
            endcase
            state_d = S_CMD;
         end
         S_CMD: begin
            tx_en_d = 1'b1;
            waddr_d = A_CR;
            wdata_d = (byte_q == 2'd0) ? CR_STA_WR :
                      (byte_q == 2'd3) ? CR_WR_STO : CR_WR;
            cnt_d   = '0;
            state_d = S_WAIT_INT;
         end
         S_WAIT_INT: begin
            if (I_iic_int) begin
               state_d = S_IACK;
            end else if (cnt_q == TMO_LAST) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_IACK: begin
            tx_en_d = 1'b1;
            waddr_d = A_CR;
            wdata_d = CR_IACK;
`ifdef OV5640_CFG_ACK_CHECK_EN
            state_d = S_RD_REQ;
`else
            if (byte_q != 2'd3) begin
               byte_d  = byte_q + 2'd1;
               state_d = S_TX;
            end else begin
               state_d = S_NEXT;
            end
`endif
         end
`ifdef OV5640_CFG_ACK_CHECK_EN
         S_RD_REQ: begin
            rx_en_d = 1'b1;
            raddr_d = A_CR;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: state_d = S_RD_CHK;
         // SR bit7 (RxACK) set means the sensor did not acknowledge
         S_RD_CHK: begin
            if (I_rdata[7]) begin
               if (retry_q == RTY_LAST) begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_ERROR;
               end else begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = S_STOP_CMD;
               end
            end else if (byte_q != 2'd3) begin
               byte_d  = byte_q + 2'd1;
               state_d = S_TX;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_STOP_CMD: begin
            tx_en_d = 1'b1;
            waddr_d = A_CR;
            wdata_d = CR_STO;
            cnt_d   = '0;
            state_d = S_STOP_WAIT;
         end
         S_STOP_WAIT: begin
            if (I_iic_int) begin
               state_d = S_STOP_IACK;
            end else if (cnt_q == TMO_LAST) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP_IACK: begin
            tx_en_d = 1'b1;
            waddr_d = A_CR;
            wdata_d = CR_IACK;
            byte_d  = '0;
            state_d = S_TX;
         end
`endif
         S_NEXT: begin
            if (soft_rst_c) begin
               cnt_d   = '0;
               state_d = S_RST_WAIT;
            end else if (O_lut_index == LAST_IDX) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               idx_d   = O_lut_index + IDX_W'(1);
               state_d = S_LOAD;
            end
         end
         S_RST_WAIT: begin
            if (cnt_q != RST_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (O_lut_index == LAST_IDX) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               idx_d   = O_lut_index + IDX_W'(1);
               state_d = S_LOAD;
            end
         end
         S_DONE:  begin done_d  = 1'b1; busy_d = 1'b0; end
         S_ERROR: begin error_d = 1'b1; busy_d = 1'b0; end
         default: state_d = S_ERROR;
      endcase
   end

endmodule

// File: tb/tb_ov5640_sccb_cfg_seq.sv
// tb_ov5640_sccb_cfg_seq: scoreboard bench for ov5640_sccb_cfg_seq with a
// behavioural I2C-master model (random interrupt latency, optional NACKs)
// and a randomized LUT. Expected register writes come from a transaction
// list built per scenario; a negedge monitor pops and compares every write.
module tb_ov5640_sccb_cfg_seq;

   localparam int N_LUT     = 8;
   localparam int T_INIT    = 10;
   localparam int T_RST     = 50;
   localparam int T_TMO     = 100;
   localparam int N_RTY     = 3;
   localparam int NACK_BYTE = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  lut_index;
   logic [31:0] lut_data;
   logic        tx_en;
   logic [2:0]  waddr;
   logic [7:0]  wdata;
   logic        rx_en;
   logic [2:0]  raddr;
   logic [7:0]  rdata;
   logic        iic_int;
   logic        busy, done, error;

   logic [31:0] lut [N_LUT];

   always #5 clk = ~clk;
   assign lut_data = lut[lut_index[2:0]];

   ov5640_sccb_cfg_seq #(
      .LUT_SIZE(N_LUT), .PRESCALE(16'd53), .INIT_DELAY(T_INIT),
      .RESET_DELAY(T_RST), .INT_TIMEOUT(T_TMO), .MAX_RETRY(N_RTY)
   ) dut (
      .I_clk(clk), .I_rst_n(rst_n), .O_lut_index(lut_index), .I_lut_data(lut_data),
      .O_tx_en(tx_en), .O_waddr(waddr), .O_wdata(wdata), .O_rx_en(rx_en),
      .O_raddr(raddr), .I_rdata(rdata), .I_iic_int(iic_int), .O_busy(busy),
      .O_done(done), .O_error(error)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // I2C master model
   int mute_idx  = -1;
   int nack_idx  = -1;
   int nack_cnt  = 0;
   int nacks_given;
   int cur_byte;
   int int_dly;
   logic int_armed;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iic_int <= 1'b0; int_armed <= 1'b0; int_dly <= 0;
         cur_byte <= 0; nacks_given <= 0; rdata <= 8'h00;
      end else begin
         if (rx_en) begin
            if (int'(lut_index) == nack_idx && cur_byte == NACK_BYTE && nacks_given < nack_cnt) begin
               rdata <= 8'h80;
               nacks_given <= nacks_given + 1;
            end else begin
               rdata <= 8'h00;
            end
         end
         if (int_armed) begin
            if (int_dly == 0) begin iic_int <= 1'b1; int_armed <= 1'b0; end
            else int_dly <= int_dly - 1;
         end
         if (tx_en && waddr == 3'd4) begin
            if (wdata == 8'h01) iic_int <= 1'b0;
            else begin
               if (wdata == 8'h90) cur_byte <= 0;
               else if (wdata == 8'h10 || wdata == 8'h50) cur_byte <= cur_byte + 1;
               if (int'(lut_index) != mute_idx) begin
                  int_armed <= 1'b1;
                  int_dly <= int'($urandom_range(20, 1));
               end
            end
         end
      end
   end

   // Scoreboard
   logic [10:0] exp_q[$];
   int first_seen = 0;
   int rel_cyc    = 0;
   int last_cyc   = 0;
   int long_gaps  = 0;
   int cr_cyc     = -1;
   int nwr        = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_en) begin
            if (first_seen == 0) begin
               check("pwr_wait_quiet", longint'(cyc - rel_cyc > T_INIT), 1);
               first_seen = 1;
            end else if (cyc - last_cyc >= T_RST) begin
               long_gaps++;
               check("rst_wait_gap_min", longint'(cyc - last_cyc > T_RST), 1);
               check("rst_wait_gap_max", longint'(cyc - last_cyc <= T_RST + 6), 1);
            end
            last_cyc = cyc;
            if (waddr == 3'd4 && wdata != 8'h01 && cr_cyc < 0 && int'(lut_index) == mute_idx)
               cr_cyc = cyc;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL extra_write: got %0h expected none", {waddr, wdata});
            end else begin
               check($sformatf("write#%0d", nwr), {waddr, wdata}, exp_q.pop_front());
            end
            nwr++;
         end
         if (rx_en) check("raddr", raddr, 4);
      end
   end

   task automatic push(input logic [2:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   // Transaction-level reference: the write list the sequence must produce.
   task automatic build_expect(input int mute, input int nidx, input int ncnt,
                               output int exp_err, output int exp_idx);
      logic [31:0] w;
      bit ok;
      exp_q.delete();
      nwr = 0;
      push(3'd0, 8'd53); push(3'd1, 8'd0); push(3'd2, 8'h80);
      exp_err = 0;
      exp_idx = N_LUT - 1;
      for (int e = 0; e < N_LUT; e++) begin
`ifdef OV5640_CFG_ACK_CHECK_EN
         int att;
         att = 0;
`endif
         ok = 1'b0;
         while (!ok) begin
            ok = 1'b1;
            for (int b = 0; b < 4; b++) begin
               w = lut[e];
               push(3'd3, w[31 - 8*b -: 8]);
               push(3'd4, (b == 0) ? 8'h90 : ((b == 3) ? 8'h50 : 8'h10));
               if (e == mute) begin exp_err = 1; exp_idx = e; return; end
               push(3'd4, 8'h01);
`ifdef OV5640_CFG_ACK_CHECK_EN
               if (e == nidx && b == NACK_BYTE && att < ncnt) begin
                  if (att == N_RTY) begin exp_err = 1; exp_idx = e; return; end
                  push(3'd4, 8'h40); push(3'd4, 8'h01);
                  att++;
                  ok = 1'b0;
                  break;
               end
`endif
            end
         end
      end
      if (nidx < 0 && ncnt < 0) exp_err = 1;
   endtask

   task automatic fill_lut();
      logic [15:0] r;
      lut[0] = 32'h78_3103_11;
      lut[1] = 32'h78_4300_61;
      lut[2] = 32'h78_3008_82;
      for (int i = 3; i < N_LUT; i++) begin
         r = 16'($urandom);
         if (r == 16'h3008) r = 16'h3009;
         lut[i] = {8'h78, r, 8'($urandom)};
      end
   endtask

   task automatic check_zero(input string p);
      check({p, "_idx"}, lut_index, 0);  check({p, "_tx_en"}, tx_en, 0);
      check({p, "_waddr"}, waddr, 0);    check({p, "_wdata"}, wdata, 0);
      check({p, "_rx_en"}, rx_en, 0);    check({p, "_raddr"}, raddr, 0);
      check({p, "_busy"}, busy, 0);      check({p, "_done"}, done, 0);
      check({p, "_error"}, error, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_release();
      first_seen = 0; long_gaps = 0; cr_cyc = -1;
      rst_n = 1'b1;
      rel_cyc = cyc;
      @(negedge clk);
      check("busy_after_release", busy, 1);
   endtask

   task automatic wait_end(input int budget, output int when);
      int n;
      n = 0;
      while (!(done || error) && n < budget) begin @(negedge clk); n++; end
      if (!(done || error)) begin
         total++; bad++;
         $display("FAIL wait_end: got no done/error expected one within %0d cycles", budget);
      end
      when = cyc;
   endtask

   task automatic check_end(input string p, input int eerr, input int eidx);
      check({p, "_done"}, done, eerr ? 0 : 1);
      check({p, "_error"}, error, eerr);
      check({p, "_busy"}, busy, 0);
      check({p, "_idx"}, lut_index, eidx);
      check({p, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      int eerr, eidx, when;
      int n;
      fill_lut();

      // Reset state, then a full run through the LUT
      repeat (10) @(negedge clk);
      check_zero("rst");
      build_expect(-1, -1, 0, eerr, eidx);
      do_release();
      wait_end(20000, when);
      check_end("run", eerr, eidx);
      check("soft_reset_gaps", long_gaps, 1);
      repeat (20) @(negedge clk);
      check("done_sticky", done, 1);

      // Interrupt never arrives for entry 3
      fill_lut();
      do_reset();
      mute_idx = 3;
      build_expect(3, -1, 0, eerr, eidx);
      do_release();
      wait_end(20000, when);
      check_end("tmo", eerr, eidx);
      check("tmo_latency", when - cr_cyc, T_TMO);
      repeat (30) @(negedge clk);
      check("tmo_idx_hold", lut_index, 3);
      check("tmo_error_sticky", error, 1);

      // Reset mid-transaction, then restart from index 0
      fill_lut();
      do_reset();
      mute_idx = -1;
      build_expect(-1, -1, 0, eerr, eidx);
      do_release();
      n = 0;
      while (!(lut_index == 10'd5 && cur_byte == 2) && n < 20000) begin @(negedge clk); n++; end
      check("reached_entry5_byte2", longint'(lut_index == 10'd5 && cur_byte == 2), 1);
      #3 rst_n = 1'b0;
      #1 check_zero("async_rst");
      repeat (5) @(negedge clk);
      build_expect(-1, -1, 0, eerr, eidx);
      do_release();
      wait_end(20000, when);
      check_end("restart", eerr, eidx);

`ifdef OV5640_CFG_ACK_CHECK_EN
      // NACK on byte 1 of entry 1 every time: retries exhaust
      do_reset();
      nack_idx = 1; nack_cnt = 4;
      build_expect(-1, 1, 4, eerr, eidx);
      do_release();
      wait_end(20000, when);
      check_end("nack4", eerr, eidx);

      // A single NACK: the retry succeeds
      do_reset();
      nack_idx = 1; nack_cnt = 1;
      build_expect(-1, 1, 1, eerr, eidx);
      do_release();
      wait_end(20000, when);
      check_end("nack1", eerr, eidx);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

endmodule
